// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control signal bundle between the pipeline datapath and pipe_hazard_ctrl.
// The master modport drives the pipeline status; the slave modport (the controller) drives the controls.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_rs1_i;
  logic [4:0]       id_rs2_i;
  logic             id_use_rs1_i;
  logic             id_use_rs2_i;
  logic             ex_memr_i;
  logic [4:0]       ex_rd_i;
  logic             ex_br_taken_i;
  logic             mem_req_i;
  logic             dmem_ready_i;
  logic             pc_en_o;
  logic             ifid_en_o;
  logic             ifid_flush_o;
  logic             idex_en_o;
  logic             idex_flush_o;
  logic             exmem_en_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  logic             mem_err_o;

  modport master (
    output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, ex_memr_i, ex_rd_i,
           ex_br_taken_i, mem_req_i, dmem_ready_i,
    input  pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o, exmem_en_o,
           stall_cnt_o, flush_cnt_o, mem_err_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, ex_memr_i, ex_rd_i,
           ex_br_taken_i, mem_req_i, dmem_ready_i,
    output pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o, exmem_en_o,
           stall_cnt_o, flush_cnt_o, mem_err_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use stall, 2-cycle branch redirect,
// data-memory freeze with a sticky timeout flag, and saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input logic                clk,
  input logic                rst_n,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int unsigned FrzW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic {StRun, StFlush} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [FrzW-1:0]  frz_q, frz_d;
  logic             mem_err_q, mem_err_d;

  logic freeze, load_use;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;

  always_comb begin
    freeze   = bus.mem_req_i & ~bus.dmem_ready_i;
    load_use = bus.ex_memr_i & (bus.ex_rd_i != 5'd0) &
               ((bus.id_use_rs1_i & (bus.ex_rd_i == bus.id_rs1_i)) |
                (bus.id_use_rs2_i & (bus.ex_rd_i == bus.id_rs2_i)));

    state_d    = state_q;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_en    = 1'b0;
    idex_flush = 1'b0;
    exmem_en   = 1'b0;

    // Reset forces every control low; freeze holds the whole pipe and the FSM.
    if (rst_n && !freeze) begin
      unique case (state_q)
        StRun: begin
          if (bus.ex_br_taken_i) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            state_d    = StFlush;
          end else if (load_use) begin
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
          end else begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
          end
        end
        StFlush: begin
          // ID and EX already hold bubbles; squash the second wrong-path fetch.
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
          idex_en    = 1'b1;
          exmem_en   = 1'b1;
          state_d    = StRun;
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_en && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + CNT_W'(1);

    flush_d = flush_q;
    if ((state_q == StRun) && (state_d == StFlush) && (flush_q != {CNT_W{1'b1}})) begin
      flush_d = flush_q + CNT_W'(1);
    end

    frz_d = '0;
    if (freeze) frz_d = (frz_q == FrzW'(TIMEOUT)) ? frz_q : frz_q + FrzW'(1);

    // Raised on the edge that completes the TIMEOUT-th consecutive freeze cycle.
    mem_err_d = mem_err_q | (freeze & ((frz_q + FrzW'(1)) >= FrzW'(TIMEOUT)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      stall_q   <= '0;
      flush_q   <= '0;
      frz_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
      frz_q     <= frz_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign bus.pc_en_o      = pc_en;
  assign bus.ifid_en_o    = ifid_en;
  assign bus.ifid_flush_o = ifid_flush;
  assign bus.idex_en_o    = idex_en;
  assign bus.idex_flush_o = idex_flush;
  assign bus.exmem_en_o   = exmem_en;
  assign bus.stall_cnt_o  = stall_q;
  assign bus.flush_cnt_o  = flush_q;
  assign bus.mem_err_o    = mem_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl (CNT_W=4, TIMEOUT=4) with a queue-based
// scoreboard: the driver pushes expected controls/counters, a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;
  localparam int unsigned CW = 4;

  // ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en}
  localparam logic [5:0] CRun   = 6'b110101;
  localparam logic [5:0] CLu    = 6'b000111;
  localparam logic [5:0] CBr    = 6'b111111;
  localparam logic [5:0] CFlush = 6'b111101;
  localparam logic [5:0] CZero  = 6'b000000;

  typedef struct packed {
    logic [5:0]    ctl;
    logic          chk;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
    logic          err;
    logic [7:0]    id;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vec = 0;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(.CNT_W(CW), .TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input logic rst, input logic memr, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                      input logic u2, input logic br, input logic mreq, input logic rdy,
                      input logic [5:0] ctl, input logic chk, input int stall,
                      input int flush, input logic err);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n            = rst;
    bus.ex_memr_i    = memr;
    bus.ex_rd_i      = rd;
    bus.id_rs1_i     = rs1;
    bus.id_use_rs1_i = u1;
    bus.id_rs2_i     = rs2;
    bus.id_use_rs2_i = u2;
    bus.ex_br_taken_i = br;
    bus.mem_req_i    = mreq;
    bus.dmem_ready_i = rdy;
    e.ctl   = ctl;
    e.chk   = chk;
    e.stall = CW'(stall);
    e.flush = CW'(flush);
    e.err   = err;
    e.id    = 8'(vec);
    q.push_back(e);
    vec++;
  endtask

  task automatic idle(input logic [5:0] ctl, input logic chk, input int stall,
                      input int flush, input logic err);
    step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
         ctl, chk, stall, flush, err);
  endtask

  // Monitor: compare once per cycle, mid-cycle, whenever an expectation is pending.
  always @(negedge clk) begin
    exp_t e;
    logic [5:0] got;
    if (q.size() > 0) begin
      e   = q.pop_front();
      got = {bus.pc_en_o, bus.ifid_en_o, bus.ifid_flush_o, bus.idex_en_o,
             bus.idex_flush_o, bus.exmem_en_o};
      n_cmp++;
      if (got !== e.ctl) begin
        n_bad++;
        $display("FAIL ctl v%0d: got %b want %b", e.id, got, e.ctl);
      end
      if (e.chk) begin
        n_cmp += 3;
        if (bus.stall_cnt_o !== e.stall) begin
          n_bad++;
          $display("FAIL stall_cnt v%0d: got %0d want %0d", e.id, bus.stall_cnt_o, e.stall);
        end
        if (bus.flush_cnt_o !== e.flush) begin
          n_bad++;
          $display("FAIL flush_cnt v%0d: got %0d want %0d", e.id, bus.flush_cnt_o, e.flush);
        end
        if (bus.mem_err_o !== e.err) begin
          n_bad++;
          $display("FAIL mem_err v%0d: got %b want %b", e.id, bus.mem_err_o, e.err);
        end
      end
    end
  end

  initial begin
    bus.ex_memr_i = 1'b0; bus.ex_rd_i = '0; bus.id_rs1_i = '0; bus.id_use_rs1_i = 1'b0;
    bus.id_rs2_i = '0; bus.id_use_rs2_i = 1'b0; bus.ex_br_taken_i = 1'b0;
    bus.mem_req_i = 1'b0; bus.dmem_ready_i = 1'b0;

    // Reset: everything low.
    step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, CZero, 1'b1, 0, 0, 1'b0);
    idle(CRun, 1'b1, 0, 0, 1'b0);
    // Load-use on rs2, then stall count visible.
    step(1'b1, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, CLu, 1'b1, 0, 0, 1'b0);
    idle(CRun, 1'b1, 1, 0, 1'b0);
    // x0 destination, and matching but unused rs1: no stall.
    step(1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, CRun, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1'b1, 5'd7, 5'd7, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, CRun, 1'b1, 1, 0, 1'b0);
    // Load-use on rs1, then branch wins over a simultaneous load-use.
    step(1'b1, 1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, CLu, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, CBr, 1'b1, 2, 0, 1'b0);
    // FLUSH ignores branch and load-use.
    step(1'b1, 1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, CFlush, 1'b1, 2, 1, 1'b0);
    idle(CRun, 1'b1, 2, 1, 1'b0);
    // Freeze over a branch for 3 cycles, then the branch proceeds.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0,
           CZero, 1'b1, 2 + i, 1, 1'b0);
    step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, CBr, 1'b1, 5, 1, 1'b0);
    idle(CFlush, 1'b1, 5, 2, 1'b0);
    idle(CRun, 1'b1, 5, 2, 1'b0);
    // Timeout: 6 freeze cycles; flag visible after the 4th freeze edge.
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0,
           CZero, 1'b1, 5 + i, 2, (i >= 4));
    step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, CRun, 1'b1, 11, 2, 1'b1);
    idle(CRun, 1'b1, 11, 2, 1'b1);
    // Reset mid-FLUSH: no residual flush afterwards, sticky flag cleared.
    step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, CBr, 1'b1, 11, 2, 1'b1);
    step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, CZero, 1'b1, 0, 0, 1'b0);
    idle(CRun, 1'b1, 0, 0, 1'b0);
    // Saturation: 20 load-use stalls on a 4-bit counter.
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b1, 5'd12, 5'd12, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
           CLu, 1'b1, (i > 15) ? 15 : i, 0, 1'b0);
    idle(CRun, 1'b1, 15, 0, 1'b0);

    for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
